// File: rtl/flit_packetizer.sv
// Packet encoder: captures {payload, destination} and streams it out as fixed-width
// flits carrying {chunk, TTL, seq, source ID}, honouring downstream backpressure.
module flit_packetizer #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int FLIT_WIDTH = 64,
    parameter int SEQ_WIDTH  = 5,
    parameter int SRC_WIDTH  = 2,
    parameter int SRC_ID     = 0,
    parameter int TTL_INIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  done
);
    localparam int HDR_W      = 2 + SEQ_WIDTH + SRC_WIDTH;
    localparam int CHUNK_W    = FLIT_WIDTH - HDR_W;
    localparam int FRAME_W    = DATA_WIDTH + ADDR_WIDTH;
    localparam int CHUNK_SAFE = (CHUNK_W < 1) ? 1 : CHUNK_W;
    localparam int NUM_FLITS  = (FRAME_W + CHUNK_SAFE - 1) / CHUNK_SAFE;
    localparam int PAD_W      = NUM_FLITS * CHUNK_SAFE;

    localparam logic [SEQ_WIDTH-1:0] LAST_SEQ = SEQ_WIDTH'(NUM_FLITS - 1);
    localparam logic [1:0]           TTL_BITS = 2'(TTL_INIT);
    localparam logic [SRC_WIDTH-1:0] SRC_BITS = SRC_WIDTH'(SRC_ID);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (CHUNK_W < 1) begin : g_bad_chunk
            $error("flit_packetizer: FLIT_WIDTH leaves no room for payload");
        end
        if (NUM_FLITS > (1 << SEQ_WIDTH)) begin : g_bad_seq
            $error("flit_packetizer: flit count exceeds sequence number range");
        end
    endgenerate

    function automatic logic [FLIT_WIDTH-1:0] make_flit(input logic [CHUNK_SAFE-1:0] chunk,
                                                        input logic [SEQ_WIDTH-1:0]  seq);
        return {chunk, TTL_BITS, seq, SRC_BITS};
    endfunction

    logic [1:0]            state_q, state_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d, seq_next;
    logic [PAD_W-1:0]      frame_q, frame_d, frame_shift, in_frame;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  out_last_q, out_last_d;
    logic                  done_q, done_d;

    // frame_q holds the not-yet-sent remainder; its low CHUNK bits feed the next flit.
    assign in_frame    = PAD_W'({in_data, in_dst});
    assign frame_shift = frame_q >> CHUNK_SAFE;
    assign seq_next    = seq_q + SEQ_WIDTH'(1);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both
    // high; a producer holding valid keeps its data stable until that edge.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        frame_d     = frame_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_flit_d  = '0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d     = S_SEND;
                    seq_d       = '0;
                    frame_d     = in_frame;
                    out_valid_d = 1'b1;
                    out_flit_d  = make_flit(in_frame[CHUNK_SAFE-1:0], '0);
                    out_last_d  = (NUM_FLITS == 1);
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_SEND: begin
                out_valid_d = 1'b1;
                out_flit_d  = out_flit_q;
                out_last_d  = out_last_q;
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_flit_d  = '0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        seq_d      = seq_next;
                        frame_d    = frame_shift;
                        out_flit_d = make_flit(frame_shift[CHUNK_SAFE-1:0], seq_next);
                        out_last_d = (seq_next == LAST_SEQ);
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seq_q       <= '0;
            frame_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            frame_q     <= frame_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
endmodule

// File: doc/flit_packetizer.md
# flit_packetizer

Parametrised packet encoder that captures one wide payload plus destination router address and emits it as a sequence of fixed-width flits toward the link-side FIFO / Aurora TX path. Each flit carries a payload chunk plus a header of TTL, flit sequence number and source router ID. Unlike the previous encoder, flit count is derived from the parameters, the output honours downstream backpressure, and the final flit is explicitly marked.

## Interface
- DATA_WIDTH, 1024, payload width in bits
- ADDR_WIDTH, 10, destination router address width
- FLIT_WIDTH, 64, output flit width (Aurora user data width)
- SEQ_WIDTH, 5, flit sequence number field width
- SRC_WIDTH, 2, source router ID field width
- SRC_ID, 0, this router's ID, placed in every flit
- TTL_INIT, 3, 2-bit TTL value placed in every flit
- Derived: HDR_W = 2 + SEQ_WIDTH + SRC_WIDTH; CHUNK_W = FLIT_WIDTH − HDR_W; FRAME_W = DATA_WIDTH + ADDR_WIDTH; NUM_FLITS = ceil(FRAME_W / CHUNK_W). Elaboration must fail if CHUNK_W < 1 or NUM_FLITS > 2^SEQ_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  payload + address available
- in_ready  out  1  block can accept a packet
- in_data  in  DATA_WIDTH  payload
- in_dst  in  ADDR_WIDTH  destination router address
- out_valid  out  1  out_flit valid
- out_ready  in  1  downstream accepts flit
- out_flit  out  FLIT_WIDTH  flit {chunk, TTL, seq, src}, MSB→LSB
- out_last  out  1  current flit is the final flit of the packet
- done  out  1  one-cycle pulse after the last flit is accepted

## Operation
- Frame = {in_data, in_dst} (address in LSBs), captured in full on the in_valid && in_ready edge; inputs are ignored at all other times.
- Flit k (k = 0..NUM_FLITS−1): chunk = frame[k*CHUNK_W +: CHUNK_W], bits beyond FRAME_W zero-filled; flit = {chunk, TTL_INIT[1:0], k[SEQ_WIDTH−1:0], SRC_ID[SRC_WIDTH−1:0]}.
- States:
  - IDLE: in_ready = 1; on accept → SEND, seq = 0.
  - SEND: out_valid = 1, out_flit = flit(seq), out_last = (seq == NUM_FLITS−1). On out_valid && out_ready: if last → DONE, else seq + 1.
  - DONE: done = 1, out_valid = 0, in_ready = 0, one cycle; → IDLE.
- in_ready, out_valid, out_flit, out_last and done are all registered outputs.
- Backpressure: while out_valid && !out_ready, out_flit, out_last and seq hold stable; out_valid never drops before acceptance.
- out_flit = 0 and out_last = 0 whenever out_valid = 0.
- Reset values: in_ready 0, out_valid 0, out_flit 0, out_last 0, done 0, state IDLE, seq 0, frame register 0. in_ready rises on the first clock edge after rst_n deasserts.
- Reset mid-packet: the packet is dropped immediately, all outputs are at reset values, and no done pulse is issued.

## Timing
- Accept at edge T: in_ready = 0 and out_valid = 1 with flit 0 from T+1.
- With out_ready held at 1: flit k is presented in cycle T+1+k; the last flit is in T+NUM_FLITS; done is high in T+NUM_FLITS+1; in_ready = 1 in T+NUM_FLITS+2.
- Minimum packet period: NUM_FLITS + 2 cycles. Each cycle with out_ready = 0 during SEND adds exactly one cycle.
- in_valid asserted while in_ready = 0 has no effect; the source holds in_valid until it sees in_ready.

## Test plan
- Defaults (CHUNK_W = 55, NUM_FLITS = 19), in_data = {32{32'hA5A5_0000 + i}}, in_dst = 10'h2A5, out_ready = 1 → 19 flits in 19 consecutive cycles. Flit 0 = {in_data[44:0], 10'h2A5, 2'b11, 5'd0, 2'b00}. Flit 18 = {11'b0, frame[1033:990], 2'b11, 5'd18, 2'b00} with out_last = 1. done pulses on the next cycle.
- Same packet, out_ready toggled 1,0,0,1 repeating → identical flit sequence; every flit is held stable while stalled; total time to done = 19 + stall cycles + 1.
- Two packets with in_valid held high → second accept occurs exactly 21 cycles after the first; its seq restarts at 0; no flit is duplicated or skipped.
- rst_n pulsed low while flit 7 is stalled → all outputs go to 0 asynchronously; done is never asserted; in_ready = 1 one edge after release; the next packet starts at seq 0.
- DATA_WIDTH = 128, ADDR_WIDTH = 10, FLIT_WIDTH = 32 (CHUNK_W = 23, NUM_FLITS = 6) → 6 flits with no padding; flit 5 chunk = frame[137:115].
- in_valid pulsed during SEND with different data → ignored; the emitted flits match the originally captured frame.
